// File: rtl/decode_pkg.sv
// Shared opcodes, control-vector type and stage state encodings for the
// PLC decode stage.
package decode_pkg;

  localparam logic [5:0] JMP     = 6'h10;
  localparam logic [5:0] IF0JUMP = 6'h11;
  localparam logic [5:0] IF1JUMP = 6'h12;
  localparam logic [5:0] CALL    = 6'h13;
  localparam logic [5:0] CAL0    = 6'h14;
  localparam logic [5:0] CAL1    = 6'h15;
  localparam logic [5:0] RET     = 6'h16;
  localparam logic [5:0] RET0    = 6'h17;
  localparam logic [5:0] RET1    = 6'h18;

  typedef struct packed {
    logic push;
    logic pop;
    logic jmp;
    logic cal;
    logic ret;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = 5'b00000;
  localparam ctrl_t CTRL_JMP  = 5'b00100;
  localparam ctrl_t CTRL_CAL  = 5'b10110;
  localparam ctrl_t CTRL_RET  = 5'b01001;

  // Call-stack depth change carried alongside the held instruction.
  typedef enum logic [1:0] {
    DELTA_NONE = 2'b00,
    DELTA_INC  = 2'b01,
    DELTA_DEC  = 2'b11
  } delta_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and decoded-side handshake bundle of the decode stage.
interface decode_stage_if #(
  parameter int PC_WIDTH          = 5,
  parameter int OPCODE_WIDTH      = 6,
  parameter int VALUE_WIDTH       = 8,
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int FLAG_COUNT        = 4,
  parameter int STACK_DEPTH       = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [INSTRUCTION_WIDTH-1:0] instr;
  logic                         in_valid;
  logic                         in_ready;
  logic [FLAG_COUNT-1:0]        flags;
  logic                         flush;

  logic                         out_valid;
  logic                         out_ready;
  logic [OPCODE_WIDTH-1:0]      op_code;
  logic [VALUE_WIDTH-1:0]       source1;
  logic [VALUE_WIDTH-1:0]       source2;
  logic [VALUE_WIDTH-1:0]       destination;
  logic [1:0]                   source1_choice;
  logic [1:0]                   source2_choice;
  logic [1:0]                   destination_choice;
  logic [PC_WIDTH-1:0]          jmp_addr;
  logic                         push;
  logic                         pop;
  logic                         jmp;
  logic                         cal;
  logic                         ret;
  logic [DEPTH_W-1:0]           depth;
  logic                         stack_err;

  modport slave (
    input  instr, in_valid, flags, flush, out_ready,
    output in_ready, out_valid, op_code, source1, source2, destination,
           source1_choice, source2_choice, destination_choice, jmp_addr,
           push, pop, jmp, cal, ret, depth, stack_err
  );

  modport master (
    output instr, in_valid, flags, flush, out_ready,
    input  in_ready, out_valid, op_code, source1, source2, destination,
           source1_choice, source2_choice, destination_choice, jmp_addr,
           push, pop, jmp, cal, ret, depth, stack_err
  );

endinterface

// File: rtl/decode_stage_branch_resolve.sv
// Resolves a decoded opcode against the selected flag and the current call
// depth into a control vector, a depth delta and a stack-error pulse.
module branch_resolve
  import decode_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int STACK_DEPTH  = 8,
  parameter int DEPTH_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic [OPCODE_WIDTH-1:0] op_code_i,
  input  logic                    f_i,
  input  logic [DEPTH_W-1:0]      depth_i,
  output ctrl_t                   ctrl_o,
  output delta_t                  delta_o,
  output logic                    err_o
);

  logic take_jmp;
  logic take_cal;
  logic take_ret;

  // *0 variants fire on a set flag, *1 variants on a clear flag.
  always_comb begin
    take_jmp = 1'b0;
    take_cal = 1'b0;
    take_ret = 1'b0;
    case (op_code_i)
      JMP:     take_jmp = 1'b1;
      IF0JUMP: take_jmp = f_i;
      IF1JUMP: take_jmp = !f_i;
      CALL:    take_cal = 1'b1;
      CAL0:    take_cal = f_i;
      CAL1:    take_cal = !f_i;
      RET:     take_ret = 1'b1;
      RET0:    take_ret = f_i;
      RET1:    take_ret = !f_i;
      default: ;
    endcase
  end

  always_comb begin
    ctrl_o  = CTRL_NONE;
    delta_o = DELTA_NONE;
    err_o   = 1'b0;
    if (take_jmp) begin
      ctrl_o = CTRL_JMP;
    end else if (take_cal) begin
      if (depth_i == DEPTH_W'(STACK_DEPTH)) begin
        err_o = 1'b1;
      end else begin
        ctrl_o  = CTRL_CAL;
        delta_o = DELTA_INC;
      end
    end else if (take_ret) begin
      if (depth_i == '0) begin
        err_o = 1'b1;
      end else begin
        ctrl_o  = CTRL_RET;
        delta_o = DELTA_DEC;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked instruction decode stage: field split, conditional
// branch resolution on a selectable flag, and guarded call-depth tracking.
//
// state    | meaning
// ST_EMPTY | no decoded instruction presented (out_valid = 0)
// ST_HELD  | decoded instruction presented, waiting for out_ready
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_WIDTH          = 5,
  parameter int OPCODE_WIDTH      = 6,
  parameter int VALUE_WIDTH       = 8,
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int FLAG_COUNT        = 4,
  parameter int STACK_DEPTH       = 8
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  stage_state_t            state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [VALUE_WIDTH-1:0]  src1_q, src1_d;
  logic [VALUE_WIDTH-1:0]  src2_q, src2_d;
  logic [VALUE_WIDTH-1:0]  dst_q, dst_d;
  logic [1:0]              src1_ch_q, src1_ch_d;
  logic [1:0]              src2_ch_q, src2_ch_d;
  logic [1:0]              dst_ch_q, dst_ch_d;
  ctrl_t                   ctrl_q, ctrl_d;
  delta_t                  delta_q, delta_d;
  logic [DEPTH_W-1:0]      depth_q, depth_d;
  logic                    err_q, err_d;

  logic                    held;
  logic                    in_ready;
  logic                    accept;
  logic                    transfer;
  logic [1:0]              cond_sel;
  logic                    f;
  ctrl_t                   res_ctrl;
  delta_t                  res_delta;
  logic                    res_err;
  logic                    unused_instr_bits;

  assign held     = (state_q == ST_HELD);
  assign in_ready = !bus.flush && (!held || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign transfer = held && bus.out_ready;
  assign cond_sel = bus.instr[INSTRUCTION_WIDTH-1 -: 2];
  assign unused_instr_bits = ^bus.instr[7:6];

  // Selector values past the last flag read as a constant 0.
  always_comb begin
    f = 1'b0;
    for (int i = 0; i < FLAG_COUNT; i++) begin
      if (int'(cond_sel) == i) f = bus.flags[i];
    end
  end

  branch_resolve #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .STACK_DEPTH  (STACK_DEPTH),
    .DEPTH_W      (DEPTH_W)
  ) u_resolve (
    .op_code_i (bus.instr[32 +: OPCODE_WIDTH]),
    .f_i       (f),
    .depth_i   (depth_q),
    .ctrl_o    (res_ctrl),
    .delta_o   (res_delta),
    .err_o     (res_err)
  );

  function automatic logic [DEPTH_W-1:0] step_depth(
    input logic [DEPTH_W-1:0] d,
    input delta_t             delta,
    input logic               undo
  );
    logic [DEPTH_W-1:0] r;
    r = d;
    case (delta)
      DELTA_INC: r = undo ? d - DEPTH_W'(1) : d + DEPTH_W'(1);
      DELTA_DEC: r = undo ? d + DEPTH_W'(1) : d - DEPTH_W'(1);
      default:   r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    dst_d     = dst_q;
    src1_ch_d = src1_ch_q;
    src2_ch_d = src2_ch_q;
    dst_ch_d  = dst_ch_q;
    ctrl_d    = ctrl_q;
    delta_d   = delta_q;
    depth_d   = depth_q;
    err_d     = err_q;

    if (bus.flush) begin
      state_d = ST_EMPTY;
      ctrl_d  = CTRL_NONE;
      delta_d = DELTA_NONE;
      // An instruction leaving this same cycle keeps its depth effect.
      if (held && !bus.out_ready) depth_d = step_depth(depth_q, delta_q, 1'b1);
    end else if (accept) begin
      state_d   = ST_HELD;
      op_d      = bus.instr[32 +: OPCODE_WIDTH];
      src1_d    = bus.instr[24 +: VALUE_WIDTH];
      src2_d    = bus.instr[16 +: VALUE_WIDTH];
      dst_d     = bus.instr[8 +: VALUE_WIDTH];
      src1_ch_d = bus.instr[5:4];
      src2_ch_d = bus.instr[3:2];
      dst_ch_d  = bus.instr[1:0];
      ctrl_d    = res_ctrl;
      delta_d   = res_delta;
      depth_d   = step_depth(depth_q, res_delta, 1'b0);
      err_d     = err_q | res_err;
    end else if (transfer) begin
      state_d = ST_EMPTY;
      ctrl_d  = CTRL_NONE;
      delta_d = DELTA_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      dst_q     <= '0;
      src1_ch_q <= '0;
      src2_ch_q <= '0;
      dst_ch_q  <= '0;
      ctrl_q    <= CTRL_NONE;
      delta_q   <= DELTA_NONE;
      depth_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      dst_q     <= dst_d;
      src1_ch_q <= src1_ch_d;
      src2_ch_q <= src2_ch_d;
      dst_ch_q  <= dst_ch_d;
      ctrl_q    <= ctrl_d;
      delta_q   <= delta_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready           = in_ready;
  assign bus.out_valid          = held;
  assign bus.op_code            = op_q;
  assign bus.source1            = src1_q;
  assign bus.source2            = src2_q;
  assign bus.destination        = dst_q;
  assign bus.source1_choice     = src1_ch_q;
  assign bus.source2_choice     = src2_ch_q;
  assign bus.destination_choice = dst_ch_q;
  assign bus.jmp_addr           = src1_q[PC_WIDTH-1:0];
  assign bus.push               = ctrl_q.push;
  assign bus.pop                = ctrl_q.pop;
  assign bus.jmp                = ctrl_q.jmp;
  assign bus.cal                = ctrl_q.cal;
  assign bus.ret                = ctrl_q.ret;
  assign bus.depth              = depth_q;
  assign bus.stack_err          = err_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven vectors through a
// scoreboard queue, plus hold/flush/reset/overflow sequences.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [39:0] instr;
    logic [3:0]  flags;
    logic [4:0]  ctrl;
    logic [3:0]  depth;
    logic        err;
  } vec_t;

  localparam logic [39:0] I_CALL = 40'h13_05_00_00_00;
  localparam logic [39:0] I_RET  = 40'h16_00_00_00_00;

  vec_t q[$];
  vec_t cur;
  vec_t tbl[13];
  int   total = 0;
  int   bad   = 0;
  logic mdl_valid = 1'b0;
  logic mdl_nxt   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [39:0] i, input logic [3:0] fl,
                              input logic [4:0] c, input int d, input logic e);
    vec_t v;
    v.instr = i;
    v.flags = fl;
    v.ctrl  = c;
    v.depth = 4'(d);
    v.err   = e;
    return v;
  endfunction

  function automatic logic [4:0] ctrl_now();
    return {bus.push, bus.pop, bus.jmp, bus.cal, bus.ret};
  endfunction

  task automatic cmp_out(input vec_t e);
    chk("op_code",     64'(bus.op_code),            64'(e.instr[37:32]));
    chk("source1",     64'(bus.source1),            64'(e.instr[31:24]));
    chk("source2",     64'(bus.source2),            64'(e.instr[23:16]));
    chk("destination", 64'(bus.destination),        64'(e.instr[15:8]));
    chk("src1_choice", 64'(bus.source1_choice),     64'(e.instr[5:4]));
    chk("src2_choice", 64'(bus.source2_choice),     64'(e.instr[3:2]));
    chk("dst_choice",  64'(bus.destination_choice), 64'(e.instr[1:0]));
    chk("jmp_addr",    64'(bus.jmp_addr),           64'(e.instr[28:24]));
    chk("ctrl",        64'(ctrl_now()),             64'(e.ctrl));
    chk("depth",       64'(bus.depth),              64'(e.depth));
    chk("stack_err",   64'(bus.stack_err),          64'(e.err));
  endtask

  task automatic chk_zero();
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_in_ready",  64'(bus.in_ready), 1);
    chk("rst_fields",    64'({bus.op_code, bus.source1, bus.source2, bus.destination,
                              bus.source1_choice, bus.source2_choice,
                              bus.destination_choice, bus.jmp_addr}), 0);
    chk("rst_ctrl",      64'(ctrl_now()), 0);
    chk("rst_depth",     64'(bus.depth), 0);
    chk("rst_stack_err", 64'(bus.stack_err), 0);
  endtask

  // Runs at the negedge, ahead of the edge that acts on the current inputs.
  task automatic monitor();
    logic exp_rdy;
    exp_rdy = !bus.flush && (!mdl_valid || bus.out_ready);
    chk("in_ready",  64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(mdl_valid));
    mdl_nxt = mdl_valid;
    if (rst) begin
      q.delete();
      mdl_nxt = 1'b0;
    end else begin
      if (mdl_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard: out_valid with no expected entry at %0t", $time);
        end else begin
          cmp_out(q[0]);
          if (bus.out_ready || bus.flush) begin
            void'(q.pop_front());
            mdl_nxt = 1'b0;
          end
        end
      end else begin
        chk("ctrl_idle", 64'(ctrl_now()), 0);
      end
      if (bus.in_valid && exp_rdy) begin
        q.push_back(cur);
        mdl_nxt = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    mdl_valid = mdl_nxt;
    #1;
  endtask

  task automatic drive(input vec_t v);
    cur          = v;
    bus.instr    = v.instr;
    bus.flags    = v.flags;
    bus.in_valid = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.flags     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    cur           = mk(40'h0, 4'h0, 5'b0, 0, 1'b0);

    tbl[0]  = mk(40'h10_0A_00_00_00, 4'b0000, 5'b00100, 0, 1'b0);
    tbl[1]  = mk(40'h51_03_00_00_00, 4'b0010, 5'b00100, 0, 1'b0);
    tbl[2]  = mk(40'h51_03_00_00_00, 4'b0000, 5'b00000, 0, 1'b0);
    tbl[3]  = mk(40'h92_07_11_22_3F, 4'b0000, 5'b00100, 0, 1'b0);
    tbl[4]  = mk(40'h92_07_00_00_00, 4'b0100, 5'b00000, 0, 1'b0);
    tbl[5]  = mk(40'hD1_1F_00_00_00, 4'b1000, 5'b00100, 0, 1'b0);
    tbl[6]  = mk(I_CALL,             4'b0000, 5'b10110, 1, 1'b0);
    tbl[7]  = mk(I_RET,              4'b0000, 5'b01001, 0, 1'b0);
    tbl[8]  = mk(40'h14_02_00_00_00, 4'b0001, 5'b10110, 1, 1'b0);
    tbl[9]  = mk(40'h15_02_00_00_00, 4'b0001, 5'b00000, 1, 1'b0);
    tbl[10] = mk(40'h18_00_00_00_00, 4'b0000, 5'b01001, 0, 1'b0);
    tbl[11] = mk(40'h17_00_00_00_00, 4'b0000, 5'b00000, 0, 1'b0);
    tbl[12] = mk(40'h01_AA_BB_CC_C6, 4'b1111, 5'b00000, 0, 1'b0);

    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    chk_zero();

    // Back-to-back table stream: one accept and one transfer per cycle.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("drain_table", 64'(q.size()), 0);

    // Fill the call stack, then overflow it.
    for (int i = 1; i <= 9; i++) begin
      drive(mk(I_CALL, 4'b0000, (i <= 8) ? 5'b10110 : 5'b00000,
               (i <= 8) ? i : 8, (i == 9)));
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(mk(I_RET, 4'b0000, 5'b01001, 7 - i, 1'b1));
      cycle();
    end

    // Reset in the middle of a stream wins over the offered accept.
    rst = 1'b1;
    drive(mk(I_CALL, 4'b0000, 5'b10110, 1, 1'b0));
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk_zero();

    // Return with an empty stack.
    drive(mk(I_RET, 4'b0000, 5'b00000, 0, 1'b1));
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("underflow_depth", 64'(bus.depth), 0);
    chk("underflow_err",   64'(bus.stack_err), 1);

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk_zero();

    // Stall with a CALL held, then flush it away.
    drive(mk(I_CALL, 4'b0000, 5'b10110, 1, 1'b0));
    cycle();
    drive(mk(I_CALL, 4'b0000, 5'b10110, 2, 1'b0));
    cycle();
    bus.out_ready = 1'b0;
    drive(mk(40'h10_0A_00_00_00, 4'b0000, 5'b00100, 2, 1'b0));
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_depth", 64'(bus.depth), 2);
    bus.flush = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 0);
    chk("flush_ctrl",      64'(ctrl_now()), 0);
    chk("flush_revert",    64'(bus.depth), 1);
    bus.out_ready = 1'b1;

    // Flush while the held CALL transfers: no revert.
    drive(mk(I_CALL, 4'b0000, 5'b10110, 2, 1'b0));
    cycle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    cycle();
    bus.flush = 1'b0;
    chk("flush_xfer_valid", 64'(bus.out_valid), 0);
    chk("flush_xfer_depth", 64'(bus.depth), 2);
    cycle();
    chk("drain_final", 64'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
